// File: rtl/bist_seq_fsm.sv
// -----------------------------------------------------------------------------
// bist_seq_fsm
//
// UART built-in self-test sequencer. It sends NUM_PATTERNS words from a
// Fibonacci LFSR through the Tx->Rx loopback and compares each received word
// with the word that was sent. For the last run it reports a saturating
// mismatch count, the index of the first failing word, and whether the run
// ended on a per-word timeout.
//
// Optional feature (compile-time macro BIST_STOP_ON_ERR_EN):
//   defined   - the first mismatch ends the run immediately
//   undefined - every word is sent regardless of mismatches
//
// Ports:
//   Clk, Rst_N         clock, synchronous active-low reset
//   BIST_Start         level request; accepted in IDLE when the path is quiet
//   BIST_Abort         ends an active run (ARM..NEXT) through DONE
//   Data_Rdy_Out       receiver has a word on Rx_Data_Out
//   Rx_Data_Out        receiver parallel data
//   RTS                receiver idle/ready
//   Tx_Busy            transmitter busy
//   BIST_Mode          loopback routing select (ARM..NEXT)
//   BIST_Tx_Data_Out   current pattern to the transmitter (0 in IDLE/DONE)
//   BIST_Tx_Start_Out  transmit request (SEND)
//   BIST_Busy          run in progress (any state but IDLE)
//   BIST_Done          one-cycle pulse in DONE
//   BIST_Error         any mismatch or timeout in the last run
//   BIST_Timeout       last run ended by a timeout
//   BIST_Err_Count     mismatches in the last run, saturating
//   BIST_Fail_Index    index of the first mismatch, all-ones if none
//   dbg_state          current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module bist_seq_fsm #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   NUM_PATTERNS   = 16,
  parameter logic [DATA_BITS-1:0] SEED           = DATA_BITS'(8'hA5),
  parameter logic [DATA_BITS-1:0] POLY           = DATA_BITS'(8'hB8),
  parameter int                   TIMEOUT_CYCLES = 4096,
  parameter int                   ERR_CNT_BITS   = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_N,
  input  logic                    BIST_Start,
  input  logic                    BIST_Abort,
  input  logic                    Data_Rdy_Out,
  input  logic [DATA_BITS-1:0]    Rx_Data_Out,
  input  logic                    RTS,
  input  logic                    Tx_Busy,
  output logic                    BIST_Mode,
  output logic [DATA_BITS-1:0]    BIST_Tx_Data_Out,
  output logic                    BIST_Tx_Start_Out,
  output logic                    BIST_Busy,
  output logic                    BIST_Done,
  output logic                    BIST_Error,
  output logic                    BIST_Timeout,
  output logic [ERR_CNT_BITS-1:0] BIST_Err_Count,
  output logic [15:0]             BIST_Fail_Index,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_RX = 3'd3,
    S_CHECK   = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // An all-zero seed would lock the XOR LFSR at zero forever.
  localparam logic [DATA_BITS-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;
  localparam logic [15:0]          LAST_IDX = 16'(NUM_PATTERNS - 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [DATA_BITS-1:0]    pattern_q, pattern_d;
  logic [DATA_BITS-1:0]    rx_q, rx_d;
  logic [15:0]             index_q, index_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             fail_idx_q, fail_idx_d;
  logic                    mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0]    tx_data_q, tx_data_d;

  logic tmo_hit;
  logic mismatch;
  logic start_ok;

  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign mismatch = (rx_q != pattern_q);
  assign start_ok = BIST_Start && !Data_Rdy_Out && RTS && !Tx_Busy;

  // Handshake with the datapath: BIST_Tx_Start_Out is held in SEND until the
  // transmitter answers with Tx_Busy; a received word is taken only in WAIT_RX
  // on Data_Rdy_Out; NEXT waits for both Tx_Busy and Data_Rdy_Out to drop so
  // the previous word cannot be mistaken for the next one.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    rx_d       = rx_q;
    index_d    = index_q;
    tmo_d      = tmo_q;
    err_cnt_d  = err_cnt_q;
    error_d    = error_q;
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d    = S_ARM;
          err_cnt_d  = '0;
          error_d    = 1'b0;
          timeout_d  = 1'b0;
          fail_idx_d = '1;
          pattern_d  = SEED_EFF;
          index_d    = '0;
        end
      end
      S_ARM: begin
        if (BIST_Abort) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SEND;
          tmo_d   = '0;
        end
      end
      S_SEND: begin
        if (BIST_Abort) begin
          state_d = S_DONE;
        end else if (Tx_Busy) begin
          state_d = S_WAIT_RX;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          error_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_RX: begin
        // Data arriving on the expiry cycle wins over the timeout.
        if (BIST_Abort) begin
          state_d = S_DONE;
        end else if (Data_Rdy_Out) begin
          state_d = S_CHECK;
          rx_d    = Rx_Data_Out;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          error_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (BIST_Abort) begin
          state_d = S_DONE;
        end else begin
          state_d = S_NEXT;
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
            error_d = 1'b1;
            if (fail_idx_q == '1) fail_idx_d = index_q;
`ifdef BIST_STOP_ON_ERR_EN
            state_d = S_DONE;
`endif
          end
        end
      end
      S_NEXT: begin
        if (BIST_Abort) begin
          state_d = S_DONE;
        end else if (index_q == LAST_IDX) begin
          state_d = S_DONE;
        end else if (!Tx_Busy && !Data_Rdy_Out) begin
          // Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
          pattern_d = {pattern_q[DATA_BITS-2:0], ^(pattern_q & POLY)};
          index_d   = index_q + 16'd1;
          tmo_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    mode_d     = (state_d == S_ARM) || (state_d == S_SEND) || (state_d == S_WAIT_RX) ||
                 (state_d == S_CHECK) || (state_d == S_NEXT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    tx_start_d = (state_d == S_SEND);
    tx_data_d  = mode_d ? pattern_d : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      rx_q       <= '0;
      index_q    <= '0;
      tmo_q      <= '0;
      err_cnt_q  <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '1;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      rx_q       <= rx_d;
      index_q    <= index_d;
      tmo_q      <= tmo_d;
      err_cnt_q  <= err_cnt_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign BIST_Mode         = mode_q;
  assign BIST_Tx_Data_Out  = tx_data_q;
  assign BIST_Tx_Start_Out = tx_start_q;
  assign BIST_Busy         = busy_q;
  assign BIST_Done         = done_q;
  assign BIST_Error        = error_q;
  assign BIST_Timeout      = timeout_q;
  assign BIST_Err_Count    = err_cnt_q;
  assign BIST_Fail_Index   = fail_idx_q;
  assign dbg_state         = state_q;

endmodule
